// File: rtl/fetch_pkg.sv
// Shared definitions for the instruction fetch unit: reset defaults, the NOP
// encoding presented while the instruction buffer holds nothing, and the
// fetch FSM state type.
package fetch_pkg;

    localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;
    localparam logic [31:0] NOP              = 32'h0000_0013;

    typedef enum logic [1:0] {
        BOOT  = 2'd0,
        FETCH = 2'd1,
        DRAIN = 2'd2
    } state_t;

endpackage

// File: rtl/fetch_fifo.sv
// Instruction buffer: a small FIFO of {pc, instr} pairs. The head entry is
// presented combinationally so decode sees it in the cycle it becomes valid.
// Entries reset to {RESET_PC, NOP} so the head shows the reset values while
// the buffer is still empty after reset.
module fetch_fifo
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter int               DEPTH    = 2,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    localparam int              PTR_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1,
    localparam int              CNT_W    = $clog2(DEPTH + 1)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             flush,
    input  logic             push,
    input  logic [WIDTH-1:0] push_pc,
    input  logic [WIDTH-1:0] push_instr,
    input  logic             pop,
    output logic [WIDTH-1:0] head_pc,
    output logic [WIDTH-1:0] head_instr,
    output logic [CNT_W-1:0] count,
    output logic             empty
);

    logic [2*WIDTH-1:0] entry_q [DEPTH];
    logic [PTR_W-1:0]   rd_ptr_reg;
    logic [PTR_W-1:0]   wr_ptr_reg;
    logic [CNT_W-1:0]   count_reg;
    logic               full;
    logic               do_push;
    logic               do_pop;

    function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] p);
        return (p == PTR_W'(DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign empty   = (count_reg == '0);
    assign full    = (count_reg == CNT_W'(DEPTH));
    assign count   = count_reg;
    assign do_pop  = pop && !empty && !flush;
    assign do_push = push && (!full || do_pop) && !flush;

    assign {head_pc, head_instr} = entry_q[rd_ptr_reg];

    genvar gi;
    generate
        for (gi = 0; gi < DEPTH; gi++) begin : g_entry
            logic [2*WIDTH-1:0] entry_reg;

            // Capture a response into this slot when the write pointer selects it
            always_ff @(posedge clk or negedge rst_n) begin
                if (!rst_n) begin
                    entry_reg <= {RESET_PC, WIDTH'(NOP)};
                end else if (do_push && (wr_ptr_reg == PTR_W'(gi))) begin
                    entry_reg <= {push_pc, push_instr};
                end
            end

            assign entry_q[gi] = entry_reg;
        end
    endgenerate

    // Pointer and occupancy bookkeeping; a flush empties the buffer outright
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else if (flush) begin
            rd_ptr_reg <= '0;
            wr_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) begin
                wr_ptr_reg <= next_ptr(wr_ptr_reg);
            end
            if (do_pop) begin
                rd_ptr_reg <= next_ptr(rd_ptr_reg);
            end
            count_reg <= count_reg + CNT_W'(do_push) - CNT_W'(do_pop);
        end
    end

    // The fetch credit scheme never lets a response arrive into a full buffer
    a_no_overflow : assert property (@(posedge clk) disable iff (!rst_n) !(push && full && !pop));

endmodule

// File: rtl/fetch_unit.sv
// Instruction fetch unit. Issues word-aligned fetches under a credit limit
// (outstanding requests plus buffered instructions never exceed DEPTH),
// buffers in-order responses with their addresses, and hands them to decode.
// A redirect flushes the buffer, restarts fetch at the new address and drops
// the responses of every request still in flight (DRAIN state).
module fetch_unit
    import fetch_pkg::*;
#(
    parameter int               WIDTH    = 32,
    parameter logic [WIDTH-1:0] RESET_PC = WIDTH'(RESET_PC_DEFAULT),
    parameter int               DEPTH    = 2
) (
    input  logic             clk,
    input  logic             rst_n,
    output logic             imem_req,
    output logic [WIDTH-1:0] imem_addr,
    input  logic             imem_gnt,
    input  logic             imem_rvalid,
    input  logic [WIDTH-1:0] imem_rdata,
    input  logic             stall,
    input  logic             redirect,
    input  logic [WIDTH-1:0] redirect_pc,
    output logic [WIDTH-1:0] instruction,
    output logic [WIDTH-1:0] pc_d,
    output logic [WIDTH-1:0] pcplus4_d,
    output logic             valid_d
);

    localparam int               CNT_W   = $clog2(DEPTH + 1);
    localparam logic [WIDTH-1:0] PC_STEP = WIDTH'(4);
    localparam logic [WIDTH-1:0] ALIGN   = ~WIDTH'(3);

    state_t           state_reg;
    logic [WIDTH-1:0] pc_reg;
    logic [WIDTH-1:0] rsp_pc_reg;
    logic [CNT_W-1:0] outstanding_reg;
    logic [CNT_W-1:0] outstanding_next;
    logic [CNT_W-1:0] discard_reg;
    logic [CNT_W-1:0] discard_next;
    logic [CNT_W-1:0] fifo_count;
    logic [CNT_W:0]   credit_used;
    logic [WIDTH-1:0] redirect_base;
    logic             fifo_empty;
    logic             grant;
    logic             rsp;
    logic             push;
    logic             pop;

    assign redirect_base = redirect_pc & ALIGN;
    assign credit_used   = {1'b0, outstanding_reg} + {1'b0, fifo_count};

    // Requests only in FETCH, only with a free credit, never alongside a redirect
    assign imem_req  = (state_reg == FETCH) && (credit_used < (CNT_W + 1)'(DEPTH)) && !redirect;
    assign imem_addr = pc_reg;

    assign grant = imem_req && imem_gnt;
    // A response with nothing outstanding is ignored rather than underflowing the count
    assign rsp   = imem_rvalid && (outstanding_reg != '0);
    // While discard is non-zero the FSM sits in DRAIN, so FETCH responses are all live
    assign push  = rsp && !redirect && (state_reg == FETCH);
    assign pop   = valid_d && !stall && !redirect;

    assign outstanding_next = outstanding_reg + CNT_W'(grant) - CNT_W'(rsp);

    // On redirect every request still in flight after this edge is stale
    assign discard_next = redirect                        ? outstanding_next :
                          (rsp && (discard_reg != '0))    ? discard_reg - 1'b1 :
                                                            discard_reg;

    // Fetch FSM, fetch PC, response PC and in-flight accounting
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg       <= BOOT;
            pc_reg          <= RESET_PC;
            rsp_pc_reg      <= RESET_PC;
            outstanding_reg <= '0;
            discard_reg     <= '0;
        end else begin
            outstanding_reg <= outstanding_next;
            discard_reg     <= discard_next;
            if (redirect) begin
                pc_reg     <= redirect_base;
                rsp_pc_reg <= redirect_base;
                state_reg  <= (discard_next != '0) ? DRAIN : FETCH;
            end else begin
                if (grant) begin
                    pc_reg <= pc_reg + PC_STEP;
                end
                if (push) begin
                    rsp_pc_reg <= rsp_pc_reg + PC_STEP;
                end
                case (state_reg)
                    BOOT:    state_reg <= FETCH;
                    FETCH:   state_reg <= FETCH;
                    DRAIN:   if (discard_next == '0) state_reg <= FETCH;
                    default: state_reg <= BOOT;
                endcase
            end
        end
    end

    fetch_fifo #(
        .WIDTH    (WIDTH),
        .DEPTH    (DEPTH),
        .RESET_PC (RESET_PC)
    ) u_fifo (
        .clk        (clk),
        .rst_n      (rst_n),
        .flush      (redirect),
        .push       (push),
        .push_pc    (rsp_pc_reg),
        .push_instr (imem_rdata),
        .pop        (pop),
        .head_pc    (pc_d),
        .head_instr (instruction),
        .count      (fifo_count),
        .empty      (fifo_empty)
    );

    assign valid_d   = !fifo_empty;
    assign pcplus4_d = pc_d + PC_STEP;

endmodule

// File: tb/tb_fetch_unit.sv
// Randomised scoreboard bench for fetch_unit. The driver plays both the
// instruction memory and decode; each live memory response pushes the
// instruction decode should eventually see. The monitor pops and compares
// whenever the DUT presents a valid instruction.
module tb_fetch_unit;

    localparam int          DEPTH    = 2;
    localparam logic [31:0] RESET_PC = 32'h0000_0000;
    localparam logic [31:0] NOP_W    = 32'h0000_0013;

    logic        clk = 1'b0;
    logic        rst_n = 1'b1;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_gnt = 1'b0;
    logic        imem_rvalid = 1'b0;
    logic [31:0] imem_rdata = '0;
    logic        stall = 1'b0;
    logic        redirect = 1'b0;
    logic [31:0] redirect_pc = '0;
    logic [31:0] instruction;
    logic [31:0] pc_d;
    logic [31:0] pcplus4_d;
    logic        valid_d;

    fetch_unit #(
        .WIDTH    (32),
        .RESET_PC (RESET_PC),
        .DEPTH    (DEPTH)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .imem_req    (imem_req),
        .imem_addr   (imem_addr),
        .imem_gnt    (imem_gnt),
        .imem_rvalid (imem_rvalid),
        .imem_rdata  (imem_rdata),
        .stall       (stall),
        .redirect    (redirect),
        .redirect_pc (redirect_pc),
        .instruction (instruction),
        .pc_d        (pc_d),
        .pcplus4_d   (pcplus4_d),
        .valid_d     (valid_d)
    );

    always #5 clk = ~clk;

    // Memory request in flight: address the DUT sent, address the model expects,
    // redirect epoch it was issued in, and first cycle it may answer.
    typedef struct {
        logic [31:0] addr;
        logic [31:0] pc;
        int          epoch;
        int          ready;
    } mreq_t;

    // Instruction decode should receive, and the first cycle it is visible.
    typedef struct {
        logic [31:0] pc;
        logic [31:0] instr;
        int          vis;
    } exp_t;

    mreq_t       mem_q[$];
    exp_t        exp_q[$];
    int          cyc = 0;
    int          epoch = 0;
    logic [31:0] fetch_model = RESET_PC;
    bit          booted = 0;
    int          tests = 0;
    int          failures = 0;

    // stimulus knobs
    int          gnt_pct = 100;
    int          rsp_pct = 100;
    int          stall_pct = 0;
    int          redir_pct = 0;
    int          lat_max = 0;
    bit          force_stall = 0;
    bit          force_redirect = 0;
    bit          redir_on_rsp = 0;
    logic [31:0] force_target = '0;

    function automatic logic [31:0] mem_word(input logic [31:0] a);
        return ~{a[15:0], a[31:16]} ^ 32'h1357_9BDF;
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %08h expected %08h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    // One memory/decode cycle: drive inputs at the falling edge, then check the
    // request side and record what the coming rising edge will do.
    task automatic step();
        bit          rsp_now;
        bit          fire_on_rsp;
        int          stale_n;
        int          vis_n;
        bit          exp_req;
        mreq_t       r;
        @(negedge clk);
        cyc++;
        rsp_now = (mem_q.size() != 0) && (mem_q[0].ready <= cyc) &&
                  ($urandom_range(99) < rsp_pct);
        imem_rvalid = rsp_now;
        imem_rdata  = rsp_now ? mem_word(mem_q[0].addr) : $urandom();
        imem_gnt    = $urandom_range(99) < gnt_pct;
        stall       = force_stall || ($urandom_range(99) < stall_pct);
        fire_on_rsp = redir_on_rsp && rsp_now;
        redirect    = force_redirect || fire_on_rsp || ($urandom_range(99) < redir_pct);
        redirect_pc = (force_redirect || fire_on_rsp) ? force_target : $urandom();
        force_redirect = 0;
        if (fire_on_rsp) redir_on_rsp = 0;
        #1;
        stale_n = 0;
        foreach (mem_q[i]) if (mem_q[i].epoch != epoch) stale_n++;
        vis_n = 0;
        foreach (exp_q[i]) if (exp_q[i].vis <= cyc) vis_n++;
        exp_req = booted && (stale_n == 0) && (mem_q.size() + vis_n < DEPTH) && !redirect;
        check("imem_req", 32'(imem_req), 32'(exp_req));
        if (imem_req && imem_gnt) check("imem_addr", imem_addr, fetch_model);
        if (rsp_now) begin
            r = mem_q.pop_front();
            if (!redirect && (r.epoch == epoch))
                exp_q.push_back('{pc: r.pc, instr: mem_word(r.pc), vis: cyc + 1});
        end
        if (imem_req && imem_gnt) begin
            mem_q.push_back('{addr: imem_addr, pc: fetch_model, epoch: epoch,
                              ready: cyc + 1 + $urandom_range(lat_max)});
            fetch_model = fetch_model + 32'd4;
        end
        if (redirect) begin
            epoch++;
            fetch_model = {redirect_pc[31:2], 2'b00};
        end
        booted = 1;
    endtask

    task automatic run(input int n);
        for (int i = 0; i < n; i++) step();
    endtask

    // Asynchronous reset in mid-cycle; outputs must change without a clock edge.
    task automatic do_reset();
        #2 rst_n = 1'b0;
        #1;
        check("rst_imem_req", 32'(imem_req), 32'd0);
        check("rst_imem_addr", imem_addr, RESET_PC);
        check("rst_valid_d", 32'(valid_d), 32'd0);
        check("rst_instruction", instruction, NOP_W);
        check("rst_pc_d", pc_d, RESET_PC);
        check("rst_pcplus4_d", pcplus4_d, RESET_PC + 32'd4);
        mem_q.delete();
        exp_q.delete();
        epoch = 0;
        fetch_model = RESET_PC;
        booted = 0;
        imem_gnt = 0;
        imem_rvalid = 0;
        stall = 0;
        redirect = 0;
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        #1;
        check("boot_imem_req", 32'(imem_req), 32'd0);
        @(posedge clk);
        #1;
        booted = 1;
    endtask

    task automatic knobs(input int g, input int r, input int s, input int d, input int l);
        gnt_pct = g; rsp_pct = r; stall_pct = s; redir_pct = d; lat_max = l;
    endtask

    // Monitor: compares the decode-side outputs against the scoreboard head
    initial begin
        bit          prev_hold;
        bit          exp_valid;
        logic [31:0] prev_pc;
        logic [31:0] prev_instr;
        exp_t        e;
        prev_hold = 0;
        prev_pc = '0;
        prev_instr = '0;
        forever begin
            @(negedge clk);
            #2;
            if (!rst_n) begin
                prev_hold = 0;
                continue;
            end
            exp_valid = (exp_q.size() != 0) && (exp_q[0].vis <= cyc);
            check("valid_d", 32'(valid_d), 32'(exp_valid));
            if (prev_hold) begin
                check("stall_hold_pc", pc_d, prev_pc);
                check("stall_hold_instr", instruction, prev_instr);
            end
            if (valid_d && exp_valid) begin
                e = exp_q[0];
                check("pc_d", pc_d, e.pc);
                check("instruction", instruction, e.instr);
                check("pcplus4_d", pcplus4_d, e.pc + 32'd4);
                if (!stall && !redirect) begin
                    void'(exp_q.pop_front());
                    $display("[TB] cycle %0d deliver pc=%08h instr=%08h", cyc, pc_d, instruction);
                end
            end
            prev_hold  = valid_d && stall && !redirect;
            prev_pc    = pc_d;
            prev_instr = instruction;
            if (redirect) exp_q.delete();
        end
    end

    initial begin
        #1_000_000;
        $display("FAIL watchdog: time limit reached, tests=%0d", tests);
        $fatal(1, "watchdog");
    end

    initial begin
        @(negedge clk);
        #1;
        do_reset();

        // zero-wait memory straight out of reset
        knobs(100, 100, 0, 0, 0);
        run(12);

        // decode stalls for five cycles while instructions are flowing
        force_stall = 1;
        run(5);
        force_stall = 0;
        run(10);

        // two requests in flight, then redirect to a misaligned target
        knobs(100, 0, 0, 0, 0);
        run(6);
        force_target = 32'h0000_0102;
        force_redirect = 1;
        knobs(100, 100, 0, 0, 0);
        run(12);

        // redirect, stall and a response all in the same cycle
        force_stall = 1;
        run(2);
        force_target = 32'h0000_0200;
        redir_on_rsp = 1;
        run(3);
        force_stall = 0;
        run(8);

        // fetch across the top of the address space
        force_target = 32'hFFFF_FFFC;
        force_redirect = 1;
        run(10);

        // randomised traffic with variable memory latency
        knobs(70, 60, 30, 4, 3);
        run(2000);

        // reset while draining stale responses
        knobs(100, 0, 0, 0, 0);
        run(5);
        force_target = 32'h0000_0400;
        force_redirect = 1;
        run(2);
        do_reset();
        knobs(100, 100, 0, 0, 0);
        run(12);

        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
